hdlc_rx_deframer: RTL
=====================

// Module: hdlc_rx_deframer
// PURPOSE
//  Serial HDLC receive controller built around the 10-state one-hot ones-run detector (S0..S6, ERR, DISC, FLAG).
//  Hunts for flags, removes stuffed zeros, assembles LSB-first bytes and delivers them with sof/eof marks.
//  Reports aborts and malformed frames. Sits between the line bit sampler and the byte-wide frame buffer.
// PARAMETERS
//  MAX_BYTES  64  max payload bytes per frame; byte MAX_BYTES+1 is a length error
//  LEN_W      7   width of frame_len, >= $clog2(MAX_BYTES+1)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  clr        in   1      sync flush: back to hunt, all counters cleared, no pulses
//  bit_valid  in   1      bit_in is valid this cycle
//  bit_in     in   1      serial line bit
//  byte_valid out  1      1-cycle pulse: byte_data/sof/eof valid
//  byte_data  out  8      payload byte, first-received bit in [0]
//  sof        out  1      with byte_valid: first byte of frame
//  eof        out  1      with byte_valid: last byte of frame (closing flag seen)
//  frame_len  out  LEN_W  byte count of frame; valid with eof
//  abort      out  1      1-cycle pulse: 7+ ones received while in frame
//  frame_err  out  1      1-cycle pulse: closing flag not byte-aligned, or length > MAX_BYTES
//  in_frame   out  1      level: frame open (opening flag seen, not yet closed/aborted)
// BEHAVIOUR
//  Reset: detector = S0; mode = HUNT; all outputs 0; byte_data 0.
//  Detector advances only on bit_valid. bit=1: S0..S5 -> next Sk; S6/ERR -> ERR; DISC/FLAG -> S1.
//  bit=0: S5 -> DISC, S6 -> FLAG, others -> S0.
//  Bit classes:
//  - DISC entry: stuffed bit, dropped.
//  - FLAG entry: flag event.
//  - ERR entry from S6: abort event.
//  - Otherwise: accepted bit.
//  Accepted bits enter a 7-bit delay line (valid count 0..7). Once full, the oldest bit shifts into the byte assembler (bit count 0..7).
//  Only done while mode = FRAME.
//  Flag event: the delay line holds exactly the 7 flag bits 0111111; clear it (count 0).
//  - HUNT: mode -> FRAME.
//  - FRAME, no bytes yet, assembler count 0: shared flag, stay FRAME.
//  - FRAME, >=1 byte, count 0: emit pending byte with eof=1 and frame_len; stay FRAME (flag opens the next frame).
//  - FRAME, count != 0: frame_err pulse; drop pending byte; stay FRAME, counters cleared.
//  Byte completion: each completed byte becomes pending. The previous pending byte (if any) is emitted with eof=0.
//  Emission timing: sof=1 on the first emitted byte of a frame. A single-byte frame has sof=eof=1 on the same pulse.
//  Length error: completing byte MAX_BYTES+1 -> frame_err pulse, drop pending, mode -> HUNT.
//  Abort event in FRAME -> abort pulse, drop pending, mode -> HUNT. Abort in HUNT is silent.
//  All pulses are registered, asserted the cycle after the bit_valid cycle that caused them. Never more than one byte_valid per bit.
//  frame_len saturates at MAX_BYTES.
//  clr and rst_n take effect mid-frame with no eof/abort emitted. clr has priority over bit_valid in the same cycle.
//  bit_valid=0: all state holds.
// STRUCTURE
//  hdlc_pkg: one-hot state index localparams (S0..S6, ERR, DISC, FLAG), state_t typedef, FLAG_BYTE=8'h7E.
//  hdlc_ones_detector: registered one-hot detector, outputs next state and stuffed/flag/abort strobes.
//  Top holds mode FSM (HUNT/FRAME), delay line, assembler, pending byte, length counter.
// TESTING
//  7E,41,7E LSB-first -> one byte_valid: byte_data=41, sof=1, eof=1, frame_len=1; in_frame stays 1.
//  7E, FF sent as 11111 0 111, 7E -> byte_data=FF sof=eof=1; the stuffed 0 is absent from the data.
//  7E,01,02,03,7E -> 3 pulses: 01 (sof), 02, 03 (eof, frame_len=3); no err/abort.
//  7E,7E,7E,41,7E -> a single one-byte frame 41; shared flags produce no output.
//  7E,41 then 7 ones -> abort pulse, no byte_valid; in_frame=0. 7E,5 data bits,7E -> frame_err only.
//  MAX_BYTES+1 bytes after 7E -> frame_err, in_frame=0. rst_n low mid-frame -> all outputs 0 immediately; next frame clean.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC receive path: ones-run detector state indices,
// the one-hot state vector type and the receive mode encoding.
package hdlc_pkg;

    localparam int unsigned S0_IDX     = 0;
    localparam int unsigned S1_IDX     = 1;
    localparam int unsigned S2_IDX     = 2;
    localparam int unsigned S3_IDX     = 3;
    localparam int unsigned S4_IDX     = 4;
    localparam int unsigned S5_IDX     = 5;
    localparam int unsigned S6_IDX     = 6;
    localparam int unsigned ERR_IDX    = 7;
    localparam int unsigned DISC_IDX   = 8;
    localparam int unsigned FLAG_IDX   = 9;
    localparam int unsigned NUM_STATES = 10;

    typedef logic [NUM_STATES-1:0] state_t;

    localparam state_t RESET_STATE = state_t'(1) << S0_IDX;

    localparam logic [7:0] FLAG_BYTE = 8'h7E;

    typedef enum logic {HUNT, FRAME} mode_t;

endpackage

// File: rtl/hdlc_ones_detector.sv
// One-hot ones-run detector: tracks consecutive ones on the serial line and
// classifies each valid bit as stuffed, flag, abort or ordinary data.
module hdlc_ones_detector
    import hdlc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic flag,
    output logic abort_ev,
    output logic accepted
);

    state_t state;
    state_t next_state;
    logic   stuffed;

    always_comb begin
        next_state = '0;
        if (bit_in) begin
            next_state[S1_IDX]  = state[S0_IDX] | state[DISC_IDX] | state[FLAG_IDX];
            next_state[S2_IDX]  = state[S1_IDX];
            next_state[S3_IDX]  = state[S2_IDX];
            next_state[S4_IDX]  = state[S3_IDX];
            next_state[S5_IDX]  = state[S4_IDX];
            next_state[S6_IDX]  = state[S5_IDX];
            next_state[ERR_IDX] = state[S6_IDX] | state[ERR_IDX];
        end else begin
            next_state[DISC_IDX] = state[S5_IDX];
            next_state[FLAG_IDX] = state[S6_IDX];
            next_state[S0_IDX]   = ~(state[S5_IDX] | state[S6_IDX]);
        end
    end

    // ERR self-loop is an ordinary bit; only the S6 -> ERR edge is an abort.
    assign stuffed  = bit_valid & next_state[DISC_IDX];
    assign flag     = bit_valid & next_state[FLAG_IDX];
    assign abort_ev = bit_valid & bit_in & state[S6_IDX];
    assign accepted = bit_valid & ~(stuffed | flag | abort_ev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else if (clr) begin
            state <= RESET_STATE;
        end else if (bit_valid) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero-unstuffing, LSB-first byte assembly
// and byte delivery with sof/eof marks, abort and frame error reporting.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned LEN_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             sof,
    output logic             eof,
    output logic [LEN_W-1:0] frame_len,
    output logic             abort,
    output logic             frame_err,
    output logic             in_frame
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    mode_t            mode;
    logic             flag;
    logic             abort_ev;
    logic             accepted;
    logic [6:0]       dl;
    logic [2:0]       dl_cnt;
    logic [7:0]       asm_sr;
    logic [2:0]       asm_cnt;
    logic [7:0]       pend_byte;
    logic             pend_valid;
    logic             sent_any;
    logic [LEN_W-1:0] byte_cnt;
    logic             take;
    logic             byte_done;
    logic             len_err;
    logic             flush;

    hdlc_ones_detector u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .flag      (flag),
        .abort_ev  (abort_ev),
        .accepted  (accepted)
    );

    // The 7-bit delay line holds back the leading 0111111 of a closing flag so
    // those bits never reach the assembler.
    assign take      = accepted & (mode == FRAME) & ~clr;
    assign byte_done = take & (dl_cnt == 3'd7) & (asm_cnt == 3'd7);
    assign len_err   = byte_done & (byte_cnt == MAX_LEN);
    assign flush     = clr | flag | abort_ev | len_err;
    assign in_frame  = (mode == FRAME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl         <= '0;
            dl_cnt     <= '0;
            asm_sr     <= '0;
            asm_cnt    <= '0;
            pend_byte  <= '0;
            pend_valid <= 1'b0;
            sent_any   <= 1'b0;
            byte_cnt   <= '0;
        end else if (flush) begin
            dl_cnt     <= '0;
            asm_cnt    <= '0;
            pend_valid <= 1'b0;
            sent_any   <= 1'b0;
            byte_cnt   <= '0;
        end else if (take) begin
            dl <= {bit_in, dl[6:1]};
            if (dl_cnt != 3'd7) begin
                dl_cnt <= dl_cnt + 3'd1;
            end else begin
                asm_sr  <= {dl[0], asm_sr[7:1]};
                asm_cnt <= asm_cnt + 3'd1;
                if (asm_cnt == 3'd7) begin
                    pend_byte  <= {dl[0], asm_sr[7:1]};
                    pend_valid <= 1'b1;
                    byte_cnt   <= byte_cnt + LEN_W'(1);
                    if (pend_valid) sent_any <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= HUNT;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_len  <= '0;
            abort      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            abort      <= 1'b0;
            frame_err  <= 1'b0;
            if (clr) begin
                mode      <= HUNT;
                byte_data <= '0;
                frame_len <= '0;
            end else if (bit_valid) begin
                if (mode == HUNT) begin
                    if (flag) mode <= FRAME;
                end else if (abort_ev) begin
                    abort <= 1'b1;
                    mode  <= HUNT;
                end else if (flag) begin
                    if (asm_cnt != 3'd0) begin
                        frame_err <= 1'b1;
                    end else if (pend_valid) begin
                        byte_valid <= 1'b1;
                        byte_data  <= pend_byte;
                        sof        <= ~sent_any;
                        eof        <= 1'b1;
                        frame_len  <= (byte_cnt > MAX_LEN) ? MAX_LEN : byte_cnt;
                    end
                end else if (byte_done) begin
                    if (len_err) begin
                        frame_err <= 1'b1;
                        mode      <= HUNT;
                    end else if (pend_valid) begin
                        byte_valid <= 1'b1;
                        byte_data  <= pend_byte;
                        sof        <= ~sent_any;
                    end
                end
            end
        end
    end

endmodule
